// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// through a single full-subtractor cell and a borrow flop.
// Optional feature macro: SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned LAST = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic             borrow;
  logic             bout_q;

  logic             accept_c;
  logic             release_c;
  logic             last_c;
  logic             d_c;
  logic             br_nxt_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    release_c = 1'b0;
    last_c    = (count == CW'(LAST));
    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          accept_c  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last_c) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_valid && out_ready) begin
          release_c = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Full-subtractor cell on the current LSBs and the running borrow
  always_comb begin
    d_c      = a_sh[0] ^ b_sh[0] ^ borrow;
    br_nxt_c = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
  end

  // Registered handshake/status flags follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_DONE);
      busy      <= (state_nxt == S_RUN);
    end
  end

  // Operand shifters, borrow chain, bit counter and result shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      borrow  <= 1'b0;
      count   <= '0;
      bout_q  <= 1'b0;
    end else if (accept_c) begin
      a_sh    <= a;
      b_sh    <= b;
      diff_sh <= '0;
      borrow  <= bin;
      count   <= '0;
    end else if (state == S_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      diff_sh <= {d_c, diff_sh[WIDTH-1:1]};
      borrow  <= br_nxt_c;
      if (last_c) begin
        bout_q <= br_nxt_c;
      end else begin
        count  <= count + CW'(1);
      end
    end
  end

  assign diff = diff_sh;
  assign bout = bout_q;

`ifdef SUB_OVF_EN
  // Signed overflow: borrow into the MSB differs from borrow out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == S_RUN && last_c) begin
      ovf <= borrow ^ br_nxt_c;
    end else if (release_c || accept_c) begin
      ovf <= 1'b0;
    end
  end
`else
  logic unused_release;
  assign unused_release = release_c;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Define SUB_OVF_EN to also exercise the signed-overflow output.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
`ifdef SUB_OVF_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .busy      (busy)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands, take the accept edge, wait for out_valid and check latency
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          input string tag);
    int n;
    @(negedge clk);
    a        = ta;
    b        = tb;
    bin      = tbin;
    in_valid = 1'b1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, " latency"}, 32'(n), 32'd8);
  endtask

  // Complete the output handshake and confirm return to IDLE
  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    #12;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst diff", 32'(diff), 32'd0);
    check("rst bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: simple subtraction
    start_op(8'h05, 8'h03, 1'b0, "t1");
    check("t1 diff", 32'(diff), 32'h02);
    check("t1 bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_EN
    check("t1 ovf", 32'(ovf), 32'd0);
`endif
    finish_op("t1");

    // 2: wrap-around
    start_op(8'h00, 8'h01, 1'b0, "t2");
    check("t2 diff", 32'(diff), 32'hFF);
    check("t2 bout", 32'(bout), 32'd1);
    finish_op("t2");

    // 3: borrow-in ripples through every bit
    start_op(8'h10, 8'h10, 1'b1, "t3");
    check("t3 diff", 32'(diff), 32'hFF);
    check("t3 bout", 32'(bout), 32'd1);
    finish_op("t3");

    // extra: borrow-in without borrow-out
    start_op(8'hFF, 8'h00, 1'b1, "t3b");
    check("t3b diff", 32'(diff), 32'hFE);
    check("t3b bout", 32'(bout), 32'd0);
    finish_op("t3b");

    // 4: consumer stall in DONE with a stray in_valid
    out_ready = 1'b0;
    start_op(8'h3C, 8'h0F, 1'b0, "t4");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = 8'hAA;
      b        = 8'h01;
      check("t4 hold out_valid", 32'(out_valid), 32'd1);
      check("t4 hold diff", 32'(diff), 32'h2D);
      check("t4 hold bout", 32'(bout), 32'd0);
      check("t4 hold in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_op("t4");
    check("t4 not taken busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t4 idle busy", 32'(busy), 32'd0);

    // 5: asynchronous reset in the middle of RUN
    @(negedge clk);
    a        = 8'hF0;
    b        = 8'h0F;
    bin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("t5 pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5 rst busy", 32'(busy), 32'd0);
    check("t5 rst in_ready", 32'(in_ready), 32'd1);
    check("t5 rst out_valid", 32'(out_valid), 32'd0);
    check("t5 rst diff", 32'(diff), 32'd0);
    check("t5 rst bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'h09, 8'h04, 1'b0, "t5");
    check("t5 diff", 32'(diff), 32'h05);
    check("t5 bout", 32'(bout), 32'd0);
    finish_op("t5");

`ifdef SUB_OVF_EN
    // 6: signed overflow cases
    start_op(8'h80, 8'h01, 1'b0, "t6a");
    check("t6a diff", 32'(diff), 32'h7F);
    check("t6a bout", 32'(bout), 32'd0);
    check("t6a ovf", 32'(ovf), 32'd1);
    finish_op("t6a");
    check("t6a ovf clear", 32'(ovf), 32'd0);
    start_op(8'h7F, 8'hFF, 1'b0, "t6b");
    check("t6b diff", 32'(diff), 32'h80);
    check("t6b bout", 32'(bout), 32'd1);
    check("t6b ovf", 32'(ovf), 32'd1);
    finish_op("t6b");
    start_op(8'h05, 8'h03, 1'b0, "t6c");
    check("t6c diff", 32'(diff), 32'h02);
    check("t6c ovf", 32'(ovf), 32'd0);
    finish_op("t6c");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
